imem_loader: RTL and testbench

Byte-stream programmer for the instruction memory; the write side of the instruction-fetch read path. It accepts a byte stream over a valid/ready handshake and assembles bytes little-endian, first byte into bits [7:0]. Each completed 32-bit word is written to the instruction memory's write port at byte-addressed, word-aligned locations. It holds the core in reset until loading ends, either on the 0xFFFFFFFF end-of-program sentinel or when memory is full.

---
 rtl/imem_loader.sv | 115 +++++++++++
 tb/tb_imem_loader.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Byte-stream programmer for the instruction memory: packs a little-endian byte stream into 32-bit words
// and writes them word-aligned from BASE_ADDR, holding the core in reset until a sentinel or a full memory ends the load.
module imem_loader #(
  parameter int          DEPTH_WORDS = 32,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter logic [31:0] SENTINEL    = 32'hFFFF_FFFF
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic [7:0]                       in_data,
  input  logic                             in_valid,
  output logic                             in_ready,
  output logic                             wr_en,
  output logic [31:0]                      wr_addr,
  output logic [31:0]                      wr_data,
  output logic [$clog2(DEPTH_WORDS):0]     word_count,
  output logic                             load_done,
  output logic                             overflow,
  output logic                             cpu_hold
);

  localparam int CW = $clog2(DEPTH_WORDS) + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(DEPTH_WORDS - 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COLLECT = 2'd1;
  localparam logic [1:0] WRITE   = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  logic [1:0]    state;
  logic [1:0]    byte_idx;
  logic [CW-1:0] word_idx;
  logic [23:0]   asm_buf;
  logic          full_term;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      byte_idx   <= 2'd0;
      word_idx   <= '0;
      asm_buf    <= 24'd0;
      full_term  <= 1'b0;
      in_ready   <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= 32'd0;
      wr_data    <= 32'd0;
      word_count <= '0;
      load_done  <= 1'b0;
      overflow   <= 1'b0;
      cpu_hold   <= 1'b1;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= COLLECT;
            in_ready   <= 1'b1;
            byte_idx   <= 2'd0;
            word_idx   <= '0;
            word_count <= '0;
            load_done  <= 1'b0;
            overflow   <= 1'b0;
            full_term  <= 1'b0;
            cpu_hold   <= 1'b1;
          end else if (state == DONE && full_term && in_valid) begin
            overflow <= 1'b1;
          end
        end

        COLLECT: begin
          if (in_valid && in_ready) begin
            byte_idx <= byte_idx + 2'd1;
            case (byte_idx)
              2'd0:    asm_buf[7:0]   <= in_data;
              2'd1:    asm_buf[15:8]  <= in_data;
              2'd2:    asm_buf[23:16] <= in_data;
              default: begin
                // Last lane goes straight into the write register, saving a cycle.
                state    <= WRITE;
                in_ready <= 1'b0;
                wr_en    <= 1'b1;
                wr_addr  <= BASE_ADDR + (32'(word_idx) << 2);
                wr_data  <= {in_data, asm_buf};
              end
            endcase
          end
        end

        WRITE: begin
          wr_en <= 1'b0;
          if (wr_data == SENTINEL) begin
            state     <= DONE;
            load_done <= 1'b1;
            cpu_hold  <= 1'b0;
          end else begin
            word_count <= word_count + CW'(1);
            word_idx   <= word_idx + CW'(1);
            if (word_count == LAST_CNT) begin
              state     <= DONE;
              full_term <= 1'b1;
              load_done <= 1'b1;
              cpu_hold  <= 1'b0;
            end else begin
              state    <= COLLECT;
              in_ready <= 1'b1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader; a word-level reference model predicts every memory write.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready, wr_en, load_done, overflow, cpu_hold;
  logic [31:0] wr_addr, wr_data;
  logic [5:0]  word_count;
  logic        in_ready2, wr_en2, load_done2, overflow2, cpu_hold2;
  logic [31:0] wr_addr2, wr_data2;
  logic [5:0]  word_count2;

  imem_loader u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .word_count(word_count), .load_done(load_done), .overflow(overflow), .cpu_hold(cpu_hold)
  );

  imem_loader #(.BASE_ADDR(32'h0000_0040)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready2), .wr_en(wr_en2), .wr_addr(wr_addr2), .wr_data(wr_data2),
    .word_count(word_count2), .load_done(load_done2), .overflow(overflow2), .cpu_hold(cpu_hold2)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0]  stim_q[$];
  logic [31:0] wa_q[$], wd_q[$], wa2_q[$];
  logic [31:0] exp_a[$], exp_d[$];
  int          exp_cnt;
  bit          exp_full;
  int          rdy_bad, hs_cnt;

  logic [74:0] rst_vec;
  localparam logic [74:0] RST_EXP = {1'b0, 1'b0, 32'h0, 32'h0, 6'h0, 1'b0, 1'b0, 1'b1};
  assign rst_vec = {in_ready, wr_en, wr_addr, wr_data, word_count, load_done, overflow, cpu_hold};

  always @(negedge clk) begin
    if (wr_en) begin
      wa_q.push_back(wr_addr);
      wd_q.push_back(wr_data);
      if (in_ready) rdy_bad++;
    end
    if (wr_en2) wa2_q.push_back(wr_addr2);
    if (in_valid && in_ready) hs_cnt++;
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    wa_q.delete(); wd_q.delete(); wa2_q.delete();
    rdy_bad = 0; hs_cnt = 0;
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int b = 0; b < 4; b++) stim_q.push_back(w[8*b +: 8]);
  endtask

  task automatic pulse_start();
    wait_cycles(1); start = 1'b1;
    wait_cycles(1); start = 1'b0;
  endtask

  // gap: 0 = back-to-back, 1 = valid every other cycle, 2 = random idle cycles
  task automatic send(input int gap);
    int i = 0, cyc = 0;
    bit idle;
    while (i < stim_q.size() && cyc < 8000) begin
      wait_cycles(1);
      idle = (gap == 1) ? cyc[0] : (gap == 2) ? ($urandom_range(0, 3) == 0) : 1'b0;
      cyc++;
      if (idle) in_valid = 1'b0;
      else begin
        in_valid = 1'b1;
        in_data  = stim_q[i];
        if (in_ready) i++;
      end
    end
    wait_cycles(1);
    in_valid = 1'b0;
    checks++;
    if (i != stim_q.size()) begin
      errors++;
      $display("FAIL send_timeout accepted %0d of %0d bytes", i, stim_q.size());
    end
  endtask

  // Reference: little-endian words, written from base until a sentinel or 32 data words.
  task automatic model(input logic [31:0] base);
    logic [31:0] w;
    exp_a.delete(); exp_d.delete(); exp_cnt = 0; exp_full = 0;
    for (int k = 0; 4 * k + 3 < stim_q.size(); k++) begin
      w = {stim_q[4*k+3], stim_q[4*k+2], stim_q[4*k+1], stim_q[4*k]};
      exp_a.push_back(base + 32'(4 * k));
      exp_d.push_back(w);
      if (w == 32'hFFFF_FFFF) break;
      exp_cnt++;
      if (exp_cnt == 32) begin exp_full = 1; break; end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    wait_cycles(2);
    checks++;
    if (rst_vec !== RST_EXP) begin errors++; $display("FAIL reset_state got %h exp %h", rst_vec, RST_EXP); end
    rst_n = 1'b1;
    wait_cycles(2);
    checks++;
    if (rst_vec !== RST_EXP) begin errors++; $display("FAIL idle_state got %h exp %h", rst_vec, RST_EXP); end
  endtask

  task automatic test_basic();
    clear_log();
    stim_q = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    pulse_start(); send(0); wait_cycles(3); model(32'h0);
    checks++;
    if (wa_q.size() != exp_a.size()) begin errors++; $display("FAIL basic_nwrites got %0d exp %0d", wa_q.size(), exp_a.size()); end
    for (int k = 0; k < exp_a.size() && k < wa_q.size(); k++) begin
      checks++;
      if (wa_q[k] !== exp_a[k] || wd_q[k] !== exp_d[k]) begin
        errors++; $display("FAIL basic_write%0d got %h:%h exp %h:%h", k, wa_q[k], wd_q[k], exp_a[k], exp_d[k]);
      end
    end
    checks++;
    if ({word_count, load_done, cpu_hold} !== {6'(exp_cnt), 1'b1, 1'b0}) begin
      errors++; $display("FAIL basic_final cnt/done/hold got %0d/%b/%b exp %0d/1/0", word_count, load_done, cpu_hold, exp_cnt);
    end
  endtask

  task automatic test_base_addr();
    checks++;
    if (wa2_q.size() < 2 || wa2_q[0] !== 32'h40 || wa2_q[1] !== 32'h44) begin
      errors++; $display("FAIL base_addr got %0d writes, first %h exp 00000040,00000044", wa2_q.size(), (wa2_q.size() > 0) ? wa2_q[0] : 32'hx);
    end
  endtask

  task automatic test_gapped();
    clear_log();
    stim_q = '{8'h37, 8'h01, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    pulse_start(); send(1); wait_cycles(3); model(32'h0);
    checks++;
    if (wa_q.size() != exp_a.size()) begin errors++; $display("FAIL gapped_nwrites got %0d exp %0d", wa_q.size(), exp_a.size()); end
    for (int k = 0; k < exp_a.size() && k < wa_q.size(); k++) begin
      checks++;
      if (wa_q[k] !== exp_a[k] || wd_q[k] !== exp_d[k]) begin
        errors++; $display("FAIL gapped_write%0d got %h:%h exp %h:%h", k, wa_q[k], wd_q[k], exp_a[k], exp_d[k]);
      end
    end
    checks++;
    if (rdy_bad != 0 || hs_cnt != 8) begin
      errors++; $display("FAIL gapped_handshake ready_in_write %0d accepted %0d exp 0 and 8", rdy_bad, hs_cnt);
    end
  endtask

  task automatic test_start_in_collect();
    clear_log();
    stim_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    pulse_start();
    fork
      send(0);
      begin wait_cycles(2); start = 1'b1; wait_cycles(1); start = 1'b0; end
    join
    wait_cycles(3); model(32'h0);
    checks++;
    if (wa_q.size() != 2 || wd_q[0] !== exp_d[0] || wa_q[0] !== exp_a[0] || wa_q[1] !== exp_a[1]) begin
      errors++; $display("FAIL start_in_collect got %0d writes first %h exp 2 writes first %h", wa_q.size(), (wd_q.size() > 0) ? wd_q[0] : 32'hx, exp_d[0]);
    end
  endtask

  task automatic test_full();
    clear_log();
    stim_q.delete();
    for (int k = 0; k < 32; k++) push_word(32'(k));
    pulse_start(); send(0); wait_cycles(3); model(32'h0);
    checks++;
    if (wa_q.size() != 32 || !exp_full) begin errors++; $display("FAIL full_nwrites got %0d exp 32", wa_q.size()); end
    for (int k = 0; k < exp_a.size() && k < wa_q.size(); k++) begin
      checks++;
      if (wa_q[k] !== exp_a[k] || wd_q[k] !== exp_d[k]) begin
        errors++; $display("FAIL full_write%0d got %h:%h exp %h:%h", k, wa_q[k], wd_q[k], exp_a[k], exp_d[k]);
      end
    end
    checks++;
    if ({word_count, load_done, overflow, in_ready} !== {6'd32, 1'b1, 1'b0, 1'b0}) begin
      errors++; $display("FAIL full_final cnt/done/ovf/rdy got %0d/%b/%b/%b exp 32/1/0/0", word_count, load_done, overflow, in_ready);
    end
    in_valid = 1'b1; in_data = 8'hAA;
    wait_cycles(1);
    checks++;
    if (overflow !== 1'b1) begin errors++; $display("FAIL overflow_set got %b exp 1", overflow); end
    in_valid = 1'b0;
    wait_cycles(2);
    checks++;
    if (overflow !== 1'b1) begin errors++; $display("FAIL overflow_sticky got %b exp 1", overflow); end
  endtask

  task automatic test_start_in_done();
    clear_log();
    pulse_start();
    checks++;
    if ({load_done, cpu_hold, overflow, in_ready, word_count} !== {1'b0, 1'b1, 1'b0, 1'b1, 6'd0}) begin
      errors++; $display("FAIL restart_clear done/hold/ovf/rdy/cnt got %b/%b/%b/%b/%0d exp 0/1/0/1/0", load_done, cpu_hold, overflow, in_ready, word_count);
    end
    stim_q.delete(); push_word(32'hCAFE_F00D); push_word(32'hFFFF_FFFF);
    send(0); wait_cycles(3); model(32'h0);
    checks++;
    if (wa_q.size() != 2 || wa_q[0] !== exp_a[0] || wd_q[0] !== exp_d[0] || word_count !== 6'(exp_cnt)) begin
      errors++; $display("FAIL restart_reload got %0d writes cnt %0d exp 2 at %h cnt %0d", wa_q.size(), word_count, exp_a[0], exp_cnt);
    end
  endtask

  task automatic test_sentinel_last();
    clear_log();
    stim_q.delete();
    for (int k = 0; k < 31; k++) push_word($urandom_range(0, 32'h7FFF_FFFF));
    push_word(32'hFFFF_FFFF);
    pulse_start(); send(2); wait_cycles(3); model(32'h0);
    checks++;
    if (wa_q.size() != 32 || wa_q[31] !== 32'h7C || wd_q[31] !== 32'hFFFF_FFFF || word_count !== 6'(exp_cnt)) begin
      errors++; $display("FAIL sentinel_last got %0d writes cnt %0d exp 32 writes cnt %0d", wa_q.size(), word_count, exp_cnt);
    end
    in_valid = 1'b1;
    wait_cycles(3);
    in_valid = 1'b0;
    checks++;
    if (overflow !== 1'b0 || load_done !== 1'b1) begin errors++; $display("FAIL sentinel_last_ovf got ovf %b done %b exp 0 1", overflow, load_done); end
  endtask

  task automatic test_reset_midload();
    clear_log();
    stim_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    pulse_start(); send(0);
    rst_n = 1'b0;
    #1;
    checks++;
    if (rst_vec !== RST_EXP) begin errors++; $display("FAIL async_reset got %h exp %h", rst_vec, RST_EXP); end
    clear_log();
    in_valid = 1'b1; in_data = 8'h55;
    wait_cycles(3);
    rst_n = 1'b1;
    wait_cycles(4);
    in_valid = 1'b0;
    checks++;
    if (wa_q.size() != 0) begin errors++; $display("FAIL reset_no_write got %0d writes exp 0", wa_q.size()); end
    stim_q = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
    pulse_start(); send(0); wait_cycles(3);
    checks++;
    if (wa_q.size() != 1 || wa_q[0] !== 32'h0 || wd_q[0] !== 32'hFFFF_FFFF || word_count !== 6'd0) begin
      errors++; $display("FAIL reset_reload got %0d writes cnt %0d exp one FFFFFFFF at 0 cnt 0", wa_q.size(), word_count);
    end
  endtask

  task automatic test_random();
    logic [31:0] w;
    for (int it = 0; it < 6; it++) begin
      clear_log();
      stim_q.delete();
      for (int k = 0; k < int'($urandom_range(1, 12)); k++) begin
        w = $urandom();
        if (w == 32'hFFFF_FFFF) w = 32'h0;
        push_word(w);
      end
      push_word(32'hFFFF_FFFF);
      pulse_start(); send(2); wait_cycles(3); model(32'h0);
      checks++;
      if (wa_q.size() != exp_a.size()) begin errors++; $display("FAIL random%0d_nwrites got %0d exp %0d", it, wa_q.size(), exp_a.size()); end
      for (int k = 0; k < exp_a.size() && k < wa_q.size(); k++) begin
        checks++;
        if (wa_q[k] !== exp_a[k] || wd_q[k] !== exp_d[k]) begin
          errors++; $display("FAIL random%0d_write%0d got %h:%h exp %h:%h", it, k, wa_q[k], wd_q[k], exp_a[k], exp_d[k]);
        end
      end
      checks++;
      if ({word_count, load_done, cpu_hold, rdy_bad} !== {6'(exp_cnt), 1'b1, 1'b0, 32'd0}) begin
        errors++; $display("FAIL random%0d_final cnt/done/hold got %0d/%b/%b exp %0d/1/0", it, word_count, load_done, cpu_hold, exp_cnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_base_addr();
    test_gapped();
    test_start_in_collect();
    test_full();
    test_start_in_done();
    test_sentinel_last();
    test_reset_midload();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
